// File: rtl/iiitb_freqdiv_prog_if.sv
// Control and status bundle for the programmable clock divider.
// div_load is a single-cycle strobe with no backpressure: every strobe is accepted,
// and pending stays high until the captured set has taken effect.
interface iiitb_freqdiv_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] high_in;
    logic             duty_mode;
    logic             div_load;
    logic             clkout;
    logic             tick;
    logic             pending;
    logic [WIDTH-1:0] active_div;

    modport master (
        output en, div_in, high_in, duty_mode, div_load,
        input  clkout, tick, pending, active_div
    );

    modport slave (
        input  en, div_in, high_in, duty_mode, div_load,
        output clkout, tick, pending, active_div
    );
endinterface

// File: rtl/iiitb_freqdiv_prog.sv
// Glitch-free programmable clock divider: WIDTH-bit divisor, 50% or programmable duty,
// shadowed settings applied only at a period boundary or while the divider is idle.
module iiitb_freqdiv_prog #(
    parameter int WIDTH = 8
) (
    input logic                 clkin,
    input logic                 rst,
    iiitb_freqdiv_prog_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_div_q, act_div_d;
    logic [WIDTH-1:0] act_high_q, act_high_d;
    logic             act_mode_q, act_mode_d;
    logic [WIDTH-1:0] sh_div_q, sh_div_d;
    logic [WIDTH-1:0] sh_high_q, sh_high_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pending_q, pending_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             pos_hi_q, pos_hi_d;
    logic             neg_hi_q, neg_hi_d;

    logic             div_ok;
    logic             boundary;
    logic             idle;
    logic [WIDTH-1:0] half_up;

    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_high_d = act_high_q;
        act_mode_d = act_mode_q;
        pending_d  = pending_q;
        run_d      = bus.en;
        sh_div_d   = bus.div_load ? bus.div_in    : sh_div_q;
        sh_high_d  = bus.div_load ? bus.high_in   : sh_high_q;
        sh_mode_d  = bus.div_load ? bus.duty_mode : sh_mode_q;

        // D=1 wraps every cycle; D-1 is only formed once D>=2 so D=0 never wraps.
        div_ok   = act_div_q > WIDTH'(1);
        boundary = bus.en && ((act_div_q == WIDTH'(1)) ||
                              (div_ok && (cnt_q == act_div_q - WIDTH'(1))));
        idle     = !bus.en || (act_div_q == '0);

        if (boundary) begin
            if (bus.div_load) begin
                act_div_d  = bus.div_in;
                act_high_d = bus.high_in;
                act_mode_d = bus.duty_mode;
            end else if (pending_q) begin
                act_div_d  = sh_div_q;
                act_high_d = sh_high_q;
                act_mode_d = sh_mode_q;
            end
            pending_d = 1'b0;
            cnt_d     = '0;
        end else if (idle) begin
            // An idle divider takes the already-shadowed set; a load on this edge waits one cycle.
            if (pending_q) begin
                act_div_d  = sh_div_q;
                act_high_d = sh_high_q;
                act_mode_d = sh_mode_q;
            end
            pending_d = bus.div_load;
            cnt_d     = '0;
        end else begin
            if (bus.div_load) pending_d = 1'b1;
            cnt_d = run_q ? cnt_q + WIDTH'(1) : '0;
        end

        half_up  = (act_div_d >> 1) + {{(WIDTH-1){1'b0}}, act_div_d[0]};
        tick_d   = bus.en && ((act_div_d == WIDTH'(1)) ||
                              ((act_div_d > WIDTH'(1)) && (cnt_d == '0)));
        pos_hi_d = bus.en && (act_div_d > WIDTH'(1)) &&
                   (act_mode_d ? (cnt_d < act_high_d) : (cnt_d < half_up));
        neg_hi_d = pos_hi_q;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q      <= '0;
            act_div_q  <= '0;
            act_high_q <= '0;
            act_mode_q <= 1'b0;
            sh_div_q   <= '0;
            sh_high_q  <= '0;
            sh_mode_q  <= 1'b0;
            pending_q  <= 1'b0;
            run_q      <= 1'b0;
            tick_q     <= 1'b0;
            pos_hi_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_high_q <= act_high_d;
            act_mode_q <= act_mode_d;
            sh_div_q   <= sh_div_d;
            sh_high_q  <= sh_high_d;
            sh_mode_q  <= sh_mode_d;
            pending_q  <= pending_d;
            run_q      <= run_d;
            tick_q     <= tick_d;
            pos_hi_q   <= pos_hi_d;
        end
    end

    // Half-cycle delayed copy stretches the high phase by half a clkin cycle for odd 50% duty.
    always_ff @(negedge clkin) begin
        if (rst) neg_hi_q <= 1'b0;
        else     neg_hi_q <= neg_hi_d;
    end

    assign bus.clkout     = (!act_mode_q && act_div_q[0]) ? (pos_hi_q & neg_hi_q) : pos_hi_q;
    assign bus.tick       = tick_q;
    assign bus.pending    = pending_q;
    assign bus.active_div = act_div_q;

endmodule

// File: tb/tb_iiitb_freqdiv_prog.sv
// Bench for iiitb_freqdiv_prog: expected per-cycle samples {tick, clkout first half,
// clkout second half, pending, active_div} are queued with the stimulus and compared in order.
module tb_iiitb_freqdiv_prog;

  localparam int WIDTH = 8;
  localparam int W     = 4 + WIDTH;

  logic clkin;
  logic rst;

  iiitb_freqdiv_prog_if #(.WIDTH(WIDTH)) bus ();

  iiitb_freqdiv_prog #(.WIDTH(WIDTH)) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] obs_w;
  int vectors;
  int miscompares;

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // Spec-level waveform for one clkin cycle at a given period phase:
  // {tick, clkout in first half-cycle, clkout in second half-cycle}.
  function automatic logic [2:0] wave(int phase, int d, bit mode, int h);
    logic t, a, b;
    t = (d == 1) || ((d >= 2) && (phase == 0));
    if (d < 2) begin
      a = 1'b0; b = 1'b0;
    end else if (mode) begin
      a = (phase < h); b = a;
    end else if ((d % 2) == 0) begin
      a = (phase < d / 2); b = a;
    end else begin
      // high from phase 0.5 up to phase (d/2)+1
      a = (phase >= 1) && (phase <= d / 2);
      b = (phase <= d / 2);
    end
    return {t, a, b};
  endfunction

  task automatic push_exp(int phase, int d, bit mode, int h, bit pend, int ad);
    exp_q.push_back({wave(phase, d, mode, h), pend, WIDTH'(ad)});
  endtask

  // driver tasks
  task automatic step();
    logic t, a, p;
    logic [WIDTH-1:0] ad;
    @(posedge clkin);
    #1;
    t = bus.tick; a = bus.clkout; p = bus.pending; ad = bus.active_div;
    @(negedge clkin);
    #1;
    obs_q.push_back({t, a, bus.clkout, p, ad});
  endtask

  task automatic cycle(bit ld, int d, bit mode, int h);
    if (ld) begin
      bus.div_in    = WIDTH'(d);
      bus.high_in   = WIDTH'(h);
      bus.duty_mode = mode;
      bus.div_load  = 1'b1;
    end else begin
      bus.div_in    = WIDTH'($urandom_range(0, 255));
      bus.high_in   = WIDTH'($urandom_range(0, 255));
      bus.duty_mode = 1'($urandom_range(0, 1));
      bus.div_load  = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    cycle(0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    cycle(1, 4, 0, 0); push_exp(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.en = 1'b0;
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL reset: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL reset: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_even_div();
    bus.en = 1'b1;
    cycle(1, 4, 0, 0); push_exp(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 0); push_exp(k % 4, 4, 0, 0, 0, 4);
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL even_div: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL even_div: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_odd_div();
    for (int k = 0; k < 15; k++) begin
      cycle(k == 0, 5, 0, 0); push_exp(k % 5, 5, 0, 0, 0, 5);
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL odd_div: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL odd_div: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_shadow_update();
    cycle(1, 4, 0, 0); push_exp(0, 4, 0, 0, 0, 4);
    cycle(0, 0, 0, 0); push_exp(1, 4, 0, 0, 0, 4);
    cycle(1, 9, 0, 0); push_exp(2, 4, 0, 0, 1, 4);
    cycle(1, 6, 0, 0); push_exp(3, 4, 0, 0, 1, 4);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 0); push_exp(k % 6, 6, 0, 0, 0, 6);
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL shadow_update: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL shadow_update: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_programmable_high();
    int highs[3] = '{3, 0, 12};
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < ((i == 0) ? 20 : 10); k++) begin
        cycle(k == 0, 10, 1, highs[i]); push_exp(k % 10, 10, 1, highs[i], 0, 10);
      end
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL programmable_high: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL programmable_high: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_tiny_divisors();
    for (int k = 0; k < 5; k++) begin
      cycle(k == 0, 1, 0, 0); push_exp(0, 1, 0, 0, 0, 1);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(k == 0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 0);
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL tiny_divisors: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL tiny_divisors: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_enable_and_reset();
    cycle(1, 7, 0, 0); push_exp(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0); push_exp(k, 7, 0, 0, 0, 7);
    end
    bus.en = 1'b0;
    cycle(0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 7);
    cycle(0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 7);
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0); push_exp(k, 7, 0, 0, 0, 7);
    end
    rst = 1'b1;
    cycle(0, 0, 0, 0); push_exp(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle(1, 3, 0, 0); push_exp(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) begin
      cycle(0, 0, 0, 0); push_exp(k % 3, 3, 0, 0, 0, 3);
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL enable_and_reset: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL enable_and_reset: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  task automatic test_random_configs();
    int d, h;
    bit mode;
    for (int i = 0; i < 6; i++) begin
      d    = $urandom_range(2, 12);
      mode = 1'($urandom_range(0, 1));
      h    = $urandom_range(0, d - 1);
      for (int k = 0; k < 2 * d; k++) begin
        cycle(k == 0, d, mode, h); push_exp(k % d, d, mode, h, 0, d);
      end
    end
    while (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL random_configs: no sample, expected %03h", exp_w);
      end else begin
        obs_w = obs_q.pop_front();
        if (obs_w !== exp_w) begin
          miscompares++;
          $display("FAIL random_configs: got tick/ca/cb/pend=%b ad=%0d, expected %b ad=%0d", obs_w[W-1:WIDTH], obs_w[WIDTH-1:0], exp_w[W-1:WIDTH], exp_w[WIDTH-1:0]);
        end
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.div_in    = '0;
    bus.high_in   = '0;
    bus.duty_mode = 1'b0;
    bus.div_load  = 1'b0;
    test_reset();
    test_even_div();
    test_odd_div();
    test_shadow_update();
    test_programmable_high();
    test_tiny_divisors();
    test_enable_and_reset();
    test_random_configs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iiitb_freqdiv_prog.md
Name: iiitb_freqdiv_prog

Overview:
Parametrised, glitch-free programmable clock divider: the second generation of the team's frequency divider. It adds a WIDTH-bit divisor, a selectable duty mode (true 50% including odd divisors, or a programmable high time), and shadowed divisor/duty updates that take effect only at a period boundary. It also adds a period-start tick and status outputs. It sits between the board clock and downstream blocks that need a derived clock or strobe.

Parameters:
WIDTH, 8, bit width of divisor, high-time and internal counters (supports divisors up to 2^WIDTH-1)

Ports:
clkin  input  1  source clock; all state on posedge except one negedge half-cycle register
rst  input  1  synchronous, active-high reset
en  input  1  divider enable; 0 holds divider idle
div_in  input  WIDTH  requested divisor D
high_in  input  WIDTH  requested high time H in clkin cycles (duty_mode=1 only)
duty_mode  input  1  0 = 50% duty, 1 = programmable high time
div_load  input  1  one-cycle strobe capturing div_in/high_in/duty_mode into the shadow set
clkout  output  1  divided clock
tick  output  1  one-cycle pulse on the first clkin cycle of each clkout period
pending  output  1  shadow set loaded but not yet applied
active_div  output  WIDTH  divisor currently in effect

Behaviour:
- Reset (rst=1 at posedge): counter=0, active_div=0, active high/mode=0, shadow=0, pending=0, tick=0, clkout=0, negedge register cleared at next negedge. After reset, clkout stays 0 until a load is applied.
- Load: div_load=1 at posedge copies the inputs into the shadow set and sets pending=1. A second load while pending overwrites the shadow; the last load wins.
- Apply: the shadow set becomes active and pending clears at the first posedge that is either a period boundary (counter == active_div-1) or any edge with en=0. At apply, the counter restarts at 0.
- Load and boundary on the same edge: the new inputs apply at that edge directly (bypassing the shadow) and pending stays 0.
- Counter: with en=1 and active_div>=2, it counts 0..D-1 and wraps to 0. With en=0, the counter is forced to 0, clkout=0 and tick=0.
- tick: registered. It is 1 during the clkin cycle where counter==0 and en=1 and D>=2.
- Mode 0, even D: clkout = (counter < D/2). High D/2 cycles, low D/2 cycles.
- Mode 0, odd D: pos_hi = (counter < (D+1)/2). A negedge register samples pos_hi. clkout = pos_hi AND neg copy. High time is D/2 cycles plus a half cycle, low time the remainder; duty is exactly 50%.
- Mode 1: clkout = (counter < H). H=0 gives constant 0. H>=D gives constant 1 while enabled.
- D=0: clkout=0, tick=0, counter held at 0. D=1: clkout=0, tick=1 every cycle. Never gate or pass clkin combinationally.
- clkout is derived only from registers, so there are no glitches at mode or divisor changes. The period in progress always completes with its old settings.
- Arithmetic is unsigned WIDTH-bit. D-1 is computed only when D>=2, so there is no wrap for D=0.
- en falling mid-period: clkout goes 0 at the next posedge and the counter resets. en rising: the counter starts at 0 and tick=1 on the first enabled cycle.
- rst mid-period behaves exactly as power-up reset at the next posedge.

Test Plan:
1. rst, load D=4 mode 0, en=1 -> clkout high 2 / low 2 cycles, tick every 4 cycles, active_div=4, pending 1 for one cycle then 0.
2. Load D=5 mode 0 -> clkout high 2.5 cycles, low 2.5 cycles (check both edge times), tick every 5 cycles.
3. While running D=4, load D=6 at counter=1 -> pending=1; D=4 period completes; the next period is 6 cycles (3 high / 3 low); pending clears at the boundary.
4. Load D=10 mode 1 H=3, then H=0, then H=12 -> 3 high / 7 low; then constant 0; then constant 1; tick every 10 cycles in all three cases.
5. D=1, then D=0 -> D=1: clkout 0, tick every cycle; D=0: clkout 0, tick 0.
6. Running D=7, drop en at counter=3, then rst mid-period, then reload D=3 -> clkout 0 next edge; after rst all outputs 0 and active_div=0; D=3 gives 1.5 high / 1.5 low.
